demux_dispatcher: RTL

Sequencing controller for the 1-to-4 demultiplexer path. It accepts words from a single upstream source over a valid/ready handshake and picks one of four destination channels, either round-robin or an explicit per-word destination. It holds each word until the chosen channel accepts it, redirecting or dropping the word on timeout, and keeps per-channel delivery counters. It sits between the upstream producer and the four channel consumers, and drives the demux select and enable.

---
 rtl/dispatch_pkg.sv | 16 +
 rtl/dispatch_decode.sv | 18 +
 rtl/demux_dispatcher.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
// Shared definitions for the 1-to-4 demux dispatcher: channel count,
// controller states and the index-to-one-hot helper.
package dispatch_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/dispatch_decode.sv
// Gated 2-to-4 decoder driving the per-channel valid lines of the demux.
module dispatch_decode
    import dispatch_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic              en,
    output logic [NUM_CH-1:0] out_valid
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        out_valid = '0;
        if (en) begin
            out_valid = onehot4(sel);
        end
    end

endmodule

// File: rtl/demux_dispatcher.sv
// Holds one upstream word at a time and offers it to a single channel, chosen
// round-robin or explicitly; redirects or drops the word when it is not taken in time.
module demux_dispatcher
    import dispatch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int TMO    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_dest,
    input  logic                mode,
    output logic                in_ready,
    output logic [3:0]          out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic [3:0]          out_ready,
    output logic [1:0]          sel,
    output logic [4*CNT_W-1:0]  out_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam bit              TMO_EN    = (TMO != 0);
    localparam int              WAIT_W    = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TMO > 0) ? TMO - 1 : 0);

    state_t                        state_q, state_d;
    logic [DATA_W-1:0]             data_q;
    logic                          mode_q;
    logic [1:0]                    dest_q;
    logic [1:0]                    rr_q;
    logic [WAIT_W-1:0]             wait_q;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]              drop_q;

    logic capture;
    logic accept;
    logic expire;

    // Acceptance is checked before timeout, so a late ready still delivers the word.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        accept  = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready[dest_q]) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end else if (TMO_EN && (wait_q == WAIT_LAST)) begin
                    expire = 1'b1;
                    if (mode_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the counters form a small register array, but they are visible outputs and are reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            mode_q <= 1'b0;
            dest_q <= '0;
            rr_q   <= '0;
            wait_q <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
        end else if (capture) begin
            data_q <= in_data;
            mode_q <= mode;
            dest_q <= mode ? in_dest : rr_q;
            wait_q <= '0;
        end else if (state_q == HOLD) begin
            if (accept) begin
                cnt_q[dest_q] <= cnt_q[dest_q] + CNT_W'(1);
                if (!mode_q) begin
                    rr_q <= dest_q + 2'd1;
                end
            end else if (expire) begin
                wait_q <= '0;
                if (mode_q) begin
                    if (drop_q != '1) begin
                        drop_q <= drop_q + CNT_W'(1);
                    end
                end else begin
                    dest_q <= dest_q + 2'd1;
                end
            end else begin
                wait_q <= wait_q + WAIT_W'(1);
            end
        end
    end

    dispatch_decode u_decode (
        .sel       (dest_q),
        .en        (state_q == HOLD),
        .out_valid (out_valid)
    );

    assign in_ready = (state_q == IDLE);
    assign out_data = data_q;
    assign sel      = dest_q;
    assign out_cnt  = cnt_q;
    assign drop_cnt = drop_q;

endmodule
